// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT result readout path.
package fft_pkg;

    // Component width used by the packed complex type.
    localparam int CPLX_WIDTH = 16;

    // The FFT data RAM returns read data one cycle after the request.
    localparam int RAM_RD_LATENCY = 1;

    // Prefetch depth: one entry per in-flight read plus one being presented.
    localparam int RD_FIFO_DEPTH = RAM_RD_LATENCY + 1;

    typedef struct packed {
        logic signed [CPLX_WIDTH-1:0] re;
        logic signed [CPLX_WIDTH-1:0] im;
    } complex_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } reader_state_t;

endpackage

// File: rtl/fft_rd_fifo.sv
// Two-entry synchronous FIFO holding RAM read data and its bin tag.
// Push is dropped only if full without a same-cycle pop; pop on empty is ignored.
module fft_rd_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage, pointers and occupancy; reset clears everything so outputs read 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fft_result_reader.sv
// Streams a finished FFT frame out of the core's data RAM in bin order.
// A read is issued only while FIFO occupancy plus the in-flight read (after
// any same-cycle pop) stays below two, so the prefetch FIFO never overflows.
// Build option: FFT_READER_HALF_SPECTRUM_EN limits the frame to bins 0..N/2.
module fft_result_reader
    import fft_pkg::*;
#(
    parameter int FFT_SIZE   = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = $clog2(FFT_SIZE)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    ram_re_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    input  logic [2*DATA_WIDTH-1:0] ram_rdata_i,
    output logic                    out_valid_o,
    output logic [2*DATA_WIDTH-1:0] out_data_o,
    output logic [ADDR_WIDTH-1:0]   out_index_o,
    output logic                    out_last_o,
    input  logic                    out_ready_i
);

`ifdef FFT_READER_HALF_SPECTRUM_EN
    localparam int LAST_BIN = FFT_SIZE / 2;
`else
    localparam int LAST_BIN = FFT_SIZE - 1;
`endif

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LAST_BIN);
    localparam int PAYLOAD_W = 1 + ADDR_WIDTH + 2 * DATA_WIDTH;

    reader_state_t         state;
    reader_state_t         state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  in_flight;
    logic [ADDR_WIDTH-1:0] flight_index;
    logic                  pop;
    logic                  credit_ok;

    logic [PAYLOAD_W-1:0]  fifo_in;
    logic [PAYLOAD_W-1:0]  fifo_head;
    logic [1:0]            fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    assign pop         = out_valid_o && out_ready_i;
    assign out_valid_o = !fifo_empty;
    assign out_last_o  = fifo_head[PAYLOAD_W-1];
    assign out_index_o = fifo_head[PAYLOAD_W-2 -: ADDR_WIDTH];
    assign out_data_o  = fifo_head[2*DATA_WIDTH-1:0];
    assign ram_addr_o  = addr;

    // Credit: a pop this cycle frees a slot for a request issued this cycle.
    assign credit_ok = fifo_full ? pop
                     : (({1'b0, fifo_count} + {2'b0, in_flight}) <
                        (3'(RD_FIFO_DEPTH) + {2'b0, pop}));

    // Returned word is tagged with its bin index and last flag on the way in.
    assign fifo_in = {(flight_index == LAST_ADDR), flight_index, ram_rdata_i};

    fft_rd_fifo #(
        .WIDTH (PAYLOAD_W)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (in_flight),
        .push_data (fifo_in),
        .pop       (pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start pulses outside IDLE are ignored.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = FETCH;
            FETCH:   if (ram_re_o && (addr == LAST_ADDR)) state_next = DRAIN;
            DRAIN:   if (pop && out_last_o) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs, including the credit-gated RAM read request.
    always_comb begin
        ram_re_o = 1'b0;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        case (state)
            FETCH: begin
                busy_o   = 1'b1;
                ram_re_o = credit_ok;
            end
            DRAIN:   busy_o = 1'b1;
            DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Read address counter and the one-deep in-flight tracker with its index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr         <= '0;
            in_flight    <= 1'b0;
            flight_index <= '0;
        end else begin
            in_flight <= ram_re_o;
            if (ram_re_o) begin
                flight_index <= addr;
                addr         <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_result_reader.sv
// Directed bench for fft_result_reader: a RAM model, a queue of expected
// beats built from the bin rule word[k] = {k, -k}, and a per-cycle compare
// process. Honours FFT_READER_HALF_SPECTRUM_EN when defined.
module tb_fft_result_reader;

    localparam int N  = 16;
    localparam int DW = 16;
    localparam int AW = 4;
`ifdef FFT_READER_HALF_SPECTRUM_EN
    localparam int NBEATS = N / 2 + 1;
    localparam logic [2*DW-1:0] LAST_WORD = 32'h0008_FFF8;
`else
    localparam int NBEATS = N;
    localparam logic [2*DW-1:0] LAST_WORD = 32'h000F_FFF1;
`endif

    logic          clk;
    logic          rst_ni;
    logic          start;
    logic          busy;
    logic          done;
    logic          ram_re;
    logic [AW-1:0] ram_addr;
    logic [2*DW-1:0] ram_rdata;
    logic          out_valid;
    logic [2*DW-1:0] out_data;
    logic [AW-1:0] out_index;
    logic          out_last;
    logic          out_ready;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    fft_result_reader #(
        .FFT_SIZE   (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start),
        .busy_o      (busy),
        .done_o      (done),
        .ram_re_o    (ram_re),
        .ram_addr_o  (ram_addr),
        .ram_rdata_i (ram_rdata),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_index_o (out_index),
        .out_last_o  (out_last),
        .out_ready_i (out_ready)
    );

    // ---------------- RAM model (1-cycle read latency) ----------------
    logic [2*DW-1:0] ram [N];

    function automatic logic [2*DW-1:0] bin_word(input int k);
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        re = DW'(k);
        im = DW'(-k);
        return {re, im};
    endfunction

    initial begin
        ram_rdata = '0;
        for (int i = 0; i < N; i++) ram[i] = bin_word(i);
    end

    always @(posedge clk) begin
        if (ram_re) ram_rdata <= ram[ram_addr];
    end

    // ---------------- scoreboard ----------------
    logic [AW+2*DW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    int              cyc = 0;
    int              issued = 0;
    int              popped = 0;
    int              done_cnt = 0;
    int              hs_cnt = 0;
    int              first_hs_cyc = 0;
    int              last_hs_cyc = 0;
    logic            last_hs_prev = 1'b0;
    logic            prev_stall = 1'b0;
    logic [AW+2*DW:0] prev_beat = '0;
    logic [2*DW-1:0] got_data [N];

    // Compare process: samples mid-low-phase, after the drivers have settled.
    always @(negedge clk) begin
        logic hs;
        logic [AW+2*DW-1:0] e;
        #2;
        if (!rst_ni) begin
            issued       = 0;
            popped       = 0;
            last_hs_prev = 1'b0;
            prev_stall   = 1'b0;
        end else begin
            hs = out_valid && out_ready;
            check("done_pulse", done, last_hs_prev);
            if (done) done_cnt++;
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_beat", {out_last, out_index, out_data}, prev_beat);
            end
            if (out_valid) check("busy_with_data", busy, 1);
            if (ram_re) check("credit_limit", ((issued - popped - (hs ? 1 : 0)) < 2), 1);
            if (hs) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got index=%0d expected no beat", out_index);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_value", {out_index, out_data}, e);
                    check("beat_last", out_last, (exp_q.size() == 0));
                    if (e[AW+2*DW-1 -: AW] == '0) first_hs_cyc = cyc;
                end
                got_data[out_index] = out_data;
                hs_cnt++;
                last_hs_cyc = cyc;
            end
            issued       = issued + (ram_re ? 1 : 0);
            popped       = popped + (hs ? 1 : 0);
            last_hs_prev = hs && out_last;
            prev_stall   = out_valid && !out_ready;
            prev_beat    = {out_last, out_index, out_data};
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    // Called just after a falling edge; returns one falling edge later.
    task automatic start_frame();
        for (int k = 0; k < NBEATS; k++) exp_q.push_back({AW'(k), bin_word(k)});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_done_seen"}, (done_cnt != d0), 1);
        @(negedge clk);
    endtask

    task automatic wait_index(input string nm, input int idx);
        int n;
        n = 0;
        while (!(out_valid && out_index == AW'(idx)) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_reach_index"}, (out_valid && out_index == AW'(idx)), 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int lat;
        int h0;
        int d0;
        int i0;

        rst_ni    = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ram_re", ram_re, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", {out_last, out_index, out_data}, 0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);

        // 1: full-rate frame
        out_ready = 1'b1;
        h0 = hs_cnt;
        d0 = done_cnt;
        start_frame();
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("t1_first_latency", lat, 2);
        wait_done("t1", 100);
        check("t1_beats", hs_cnt - h0, NBEATS);
        check("t1_done_count", done_cnt - d0, 1);
        check("t1_back_to_back", last_hs_cyc - first_hs_cyc, NBEATS - 1);
        check("t1_queue_empty", exp_q.size(), 0);
        check("t1_word0", got_data[0], 32'h0000_0000);
        check("t1_word1", got_data[1], 32'h0001_FFFF);
        check("t1_word5", got_data[5], 32'h0005_FFFB);
        check("t1_word_last", got_data[NBEATS-1], LAST_WORD);
        check("t1_idle_busy", busy, 0);
        check("t1_idle_valid", out_valid, 0);

        // 2: ready toggling every cycle
        h0 = hs_cnt;
        out_ready = 1'b1;
        start_frame();
        begin
            int n;
            d0 = done_cnt;
            n  = 0;
            while (done_cnt == d0 && n < 200) begin
                out_ready = ~out_ready;
                @(negedge clk);
                n++;
            end
            check("t2_done_seen", (done_cnt != d0), 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t2_beats", hs_cnt - h0, NBEATS);
        check("t2_queue_empty", exp_q.size(), 0);

        // 3: long stall right after start
        out_ready = 1'b0;
        h0 = hs_cnt;
        i0 = issued;
        start_frame();
        repeat (10) @(negedge clk);
        check("t3_reads_while_stalled", issued - i0, 2);
        check("t3_valid_held", out_valid, 1);
        check("t3_head_index", out_index, 0);
        out_ready = 1'b1;
        wait_done("t3", 100);
        check("t3_beats", hs_cnt - h0, NBEATS);
        check("t3_queue_empty", exp_q.size(), 0);

        // 4: start re-pulsed mid-frame is ignored
        h0 = hs_cnt;
        d0 = done_cnt;
        start_frame();
        wait_index("t4", 5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t4", 100);
        repeat (6) @(negedge clk);
        check("t4_beats", hs_cnt - h0, NBEATS);
        check("t4_single_done", done_cnt - d0, 1);
        check("t4_stays_idle", busy, 0);

        // 5: reset in the middle of a frame
        d0 = done_cnt;
        start_frame();
        wait_index("t5", 7);
        rst_ni = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_ram_re", ram_re, 0);
        check("t5_rst_beat", {out_last, out_index, out_data}, 0);
        exp_q.delete();
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_no_done", done_cnt - d0, 0);
        h0 = hs_cnt;
        start_frame();
        wait_done("t5", 100);
        check("t5_beats", hs_cnt - h0, NBEATS);
        check("t5_queue_empty", exp_q.size(), 0);
        check("t5_word0", got_data[0], 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
